// File: rtl/mem_done_ctrl.sv
// Per-memory access controller: runs one access per step against a multi-cycle
// backing memory and holds done/rdata until the step pulse consumes them.
module mem_done_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic buf_hit_c;
  logic tmo_c;

  assign buf_hit_c = buf_valid_q && (buf_addr_q == addr);
  assign tmo_c     = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!req || (!wr && buf_hit_c)) state_d = S_DONE;
        else                            state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack || tmo_c) state_d = S_DONE;
      end
      S_DONE: begin
        if (step) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath/output next values; an ack wins over a timeout in the same cycle
  always_comb begin
    done_d      = done_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    case (state_q)
      S_IDLE: begin
        if (!req) begin
          done_d  = 1'b1;
          rdata_d = '0;
        end else if (!wr && buf_hit_c) begin
          done_d  = 1'b1;
          rdata_d = buf_data_q;
        end else begin
          mem_req_d   = 1'b1;
          mem_wr_d    = wr;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          cnt_d       = '0;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          done_d    = 1'b1;
          if (!mem_wr_q) begin
            rdata_d     = mem_rdata;
            buf_addr_d  = mem_addr_q;
            buf_data_d  = mem_rdata;
            buf_valid_d = 1'b1;
          end else begin
            rdata_d = '0;
            if (buf_addr_q == mem_addr_q) buf_data_d = mem_wdata_q;
          end
        end else if (tmo_c) begin
          mem_req_d   = 1'b0;
          mem_wr_d    = 1'b0;
          err_d       = 1'b1;
          done_d      = 1'b1;
          rdata_d     = '0;
          buf_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (step) done_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_done_ctrl.sv
// Scoreboarded bench for mem_done_ctrl: a backing-memory responder drives ack
// timing while expected results are queued per access and compared on done.
module tb_mem_done_ctrl;

  logic        clk;
  logic        rst;
  logic        step;
  logic        req;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        done;
  logic [15:0] rdata;
  logic        err;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int checks = 0;
  int passes = 0;
  int overlap_n = 0;

  typedef struct {
    logic [15:0] rdata;
    int          lat;
    int          mreq;
  } exp_t;

  exp_t exp_q[$];

  mem_done_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done && mem_req) overlap_n++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one access from the current IDLE cycle and acts as backing memory.
  // Returns when done is seen (lat = cycles after the sample cycle) or budget ends.
  task automatic run_access(input logic r, input logic w, input logic [15:0] a,
                            input logic [15:0] d, input int ack_dly,
                            input logic [15:0] ack_data, input logic step_in_wait,
                            output int lat, output int mreq_n, output logic [15:0] obs,
                            output logic obs_wr, output logic [15:0] obs_addr);
    lat = -1; mreq_n = 0; obs = 16'hxxxx; obs_wr = 1'bx; obs_addr = 16'hxxxx;
    req = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      mem_ack = 1'b0; step = 1'b0; mem_rdata = 16'hDEAD;
      if (done) begin
        lat = k; obs = rdata;
        break;
      end
      if (mem_req) begin
        mreq_n++; obs_wr = mem_wr; obs_addr = mem_addr;
        if (ack_dly >= 0 && mreq_n == ack_dly + 1) begin
          mem_ack = 1'b1; mem_rdata = ack_data;
        end
        if (step_in_wait) step = 1'b1;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; step = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passes++;
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else passes++;
    checks++; if (rdata !== 16'h0) $display("FAIL rst_rdata: got %h want 0000", rdata); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_no_access();
    int lat, mn; logic [15:0] obs; logic ow; logic [15:0] oa; exp_t e;
    exp_q.push_back('{16'h0000, 1, 0});
    run_access(1'b0, 1'b0, 16'h0010, 16'h0, -1, 16'h0, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) $display("FAIL noacc_lat: got %0d want %0d", lat, e.lat); else passes++;
    checks++; if (obs !== e.rdata) $display("FAIL noacc_rdata: got %h want %h", obs, e.rdata); else passes++;
    checks++; if (mn !== e.mreq) $display("FAIL noacc_mem_req: got %0d cycles want %0d", mn, e.mreq); else passes++;
    do_step();
    checks++; if (done !== 1'b0) $display("FAIL noacc_step: done=%b want 0", done); else passes++;
  endtask

  task automatic test_read_hit();
    int lat, mn; logic [15:0] obs; logic ow; logic [15:0] oa; exp_t e;
    exp_q.push_back('{16'hBEEF, 5, 4});
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 3, 16'hBEEF, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) $display("FAIL rd_miss_lat: got %0d want %0d", lat, e.lat); else passes++;
    checks++; if (obs !== e.rdata) $display("FAIL rd_miss_rdata: got %h want %h", obs, e.rdata); else passes++;
    checks++; if (mn !== e.mreq) $display("FAIL rd_miss_mem_req: got %0d want %0d", mn, e.mreq); else passes++;
    checks++; if (oa !== 16'h0040 || ow !== 1'b0) $display("FAIL rd_miss_bus: addr=%h wr=%b want 0040/0", oa, ow); else passes++;
    do_step();
    checks++; if (done !== 1'b0) $display("FAIL rd_miss_step: done=%b want 0", done); else passes++;
    exp_q.push_back('{16'hBEEF, 1, 0});
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 0, 16'h1111, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) $display("FAIL rd_hit_lat: got %0d want %0d", lat, e.lat); else passes++;
    checks++; if (obs !== e.rdata) $display("FAIL rd_hit_rdata: got %h want %h", obs, e.rdata); else passes++;
    checks++; if (mn !== e.mreq) $display("FAIL rd_hit_mem_req: got %0d want %0d", mn, e.mreq); else passes++;
    do_step();
  endtask

  task automatic test_write_update();
    int lat, mn; logic [15:0] obs; logic ow; logic [15:0] oa; exp_t e;
    exp_q.push_back('{16'h0000, 3, 2});
    run_access(1'b1, 1'b1, 16'h0040, 16'h1234, 1, 16'h9999, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat) $display("FAIL wr_lat: got %0d want %0d", lat, e.lat); else passes++;
    checks++; if (obs !== e.rdata) $display("FAIL wr_rdata: got %h want %h", obs, e.rdata); else passes++;
    checks++; if (mn !== e.mreq || ow !== 1'b1) $display("FAIL wr_mem_req: cycles=%0d wr=%b want %0d/1", mn, ow, e.mreq); else passes++;
    do_step();
    exp_q.push_back('{16'h1234, 1, 0});
    run_access(1'b1, 1'b0, 16'h0040, 16'h0, 0, 16'h2222, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (obs !== e.rdata || lat !== e.lat) $display("FAIL wr_hit: rdata=%h lat=%0d want %h/%0d", obs, lat, e.rdata, e.lat); else passes++;
    checks++; if (mn !== e.mreq) $display("FAIL wr_hit_mem_req: got %0d want %0d", mn, e.mreq); else passes++;
    do_step();
    exp_q.push_back('{16'h5555, 2, 1});
    run_access(1'b1, 1'b0, 16'h0042, 16'h0, 0, 16'h5555, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (mn !== e.mreq || oa !== 16'h0042) $display("FAIL other_miss: cycles=%0d addr=%h want %0d/0042", mn, oa, e.mreq); else passes++;
    checks++; if (obs !== e.rdata || lat !== e.lat) $display("FAIL other_rdata: rdata=%h lat=%0d want %h/%0d", obs, lat, e.rdata, e.lat); else passes++;
    do_step();
  endtask

  task automatic test_reset_mid_wait();
    int lat, mn; logic [15:0] obs; logic ow; logic [15:0] oa; exp_t e;
    req = 1'b1; wr = 1'b0; addr = 16'h0077;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1) $display("FAIL midrst_pre: mem_req=%b want 1", mem_req); else passes++;
    rst = 1'b1; #1;
    checks++; if (mem_req !== 1'b0 || done !== 1'b0 || err !== 1'b0)
      $display("FAIL midrst_drop: mem_req=%b done=%b err=%b want 0/0/0", mem_req, done, err); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back('{16'h0A0A, 2, 1});
    run_access(1'b1, 1'b0, 16'h0042, 16'h0, 0, 16'h0A0A, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (mn !== e.mreq) $display("FAIL midrst_buf_inval: mem_req cycles=%0d want %0d", mn, e.mreq); else passes++;
    checks++; if (obs !== e.rdata || lat !== e.lat) $display("FAIL midrst_rdata: rdata=%h lat=%0d want %h/%0d", obs, lat, e.rdata, e.lat); else passes++;
    do_step();
  endtask

  task automatic test_step_ignored();
    int lat, mn; logic [15:0] obs; logic ow; logic [15:0] oa; exp_t e;
    exp_q.push_back('{16'hC0DE, 4, 3});
    run_access(1'b1, 1'b0, 16'h0100, 16'h0, 2, 16'hC0DE, 1'b1, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (lat !== e.lat || mn !== e.mreq) $display("FAIL stepwait_lat: lat=%0d cycles=%0d want %0d/%0d", lat, mn, e.lat, e.mreq); else passes++;
    checks++; if (obs !== e.rdata) $display("FAIL stepwait_rdata: got %h want %h", obs, e.rdata); else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (done !== 1'b1 || rdata !== e.rdata) $display("FAIL stepwait_hold: done=%b rdata=%h want 1/%h", done, rdata, e.rdata); else passes++;
    do_step();
    checks++; if (done !== 1'b0) $display("FAIL stepwait_step: done=%b want 0", done); else passes++;
  endtask

  task automatic test_timeout();
    int lat, mn; logic [15:0] obs; logic ow; logic [15:0] oa; exp_t e;
    exp_q.push_back('{16'h0000, 9, 8});
    run_access(1'b1, 1'b0, 16'h0200, 16'h0, -1, 16'h0, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (mn !== e.mreq) $display("FAIL tmo_mem_req: cycles=%0d want %0d", mn, e.mreq); else passes++;
    checks++; if (lat !== e.lat || obs !== e.rdata) $display("FAIL tmo_done: lat=%0d rdata=%h want %0d/%h", lat, obs, e.lat, e.rdata); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL tmo_err: got %b want 1", err); else passes++;
    do_step();
    exp_q.push_back('{16'h7777, 2, 1});
    run_access(1'b1, 1'b0, 16'h0100, 16'h0, 0, 16'h7777, 1'b0, lat, mn, obs, ow, oa);
    e = exp_q.pop_front();
    checks++; if (mn !== e.mreq || obs !== e.rdata) $display("FAIL tmo_buf_inval: cycles=%0d rdata=%h want %0d/%h", mn, obs, e.mreq, e.rdata); else passes++;
    checks++; if (err !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", err); else passes++;
    do_step();
    rst = 1'b1; #1;
    checks++; if (err !== 1'b0) $display("FAIL tmo_err_rst: got %b want 0", err); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_access();
    test_read_hit();
    test_write_update();
    test_reset_mid_wait();
    test_step_ignored();
    test_timeout();
    @(negedge clk);
    checks++; if (overlap_n !== 0) $display("FAIL done_with_mem_req: %0d cycles want 0", overlap_n); else passes++;
    checks++; if (exp_q.size() !== 0) $display("FAIL scoreboard_left: %0d entries want 0", exp_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
